hazard_scoreboard: RTL

- Parametrised next-generation hazard unit for the in-order RISC-V pipeline.
- Sits beside the decode stage:
  - resolves RAW operand forwarding from NFWD ordered forwarding sources;
  - detects load-use hazards;
  - tracks outstanding multi-cycle (mul/div) destinations in a register scoreboard;
  - arbitrates stall vs. flush on branch redirect;
  - counts stall cycles for performance analysis.

---
 rtl/hazard_scoreboard_if.sv | 57 +++++
 rtl/hazard_scoreboard.sv | 109 ++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_if.sv
// Decode-side hazard bus: operand/destination info and forwarding sources in,
// stall/flush controls, forwarded operands and scoreboard state out.
interface hazard_scoreboard_if #(
    parameter int XLEN   = 64,
    parameter int NREG   = 32,
    parameter int NFWD   = 3,
    parameter int MC_MAX = 2,
    parameter int CNTW   = 32
);
    localparam int AW = $clog2(NREG);
    localparam int OW = $clog2(MC_MAX + 1);

    logic [AW-1:0]        id_rs1;
    logic [AW-1:0]        id_rs2;
    logic                 id_rs1_used;
    logic                 id_rs2_used;
    logic [AW-1:0]        id_rd;
    logic                 id_rd_we;
    logic                 id_is_mc;
    logic [NFWD-1:0]      fwd_valid;
    logic [NFWD*AW-1:0]   fwd_dst;
    logic [NFWD*XLEN-1:0] fwd_data;
    logic [NFWD-1:0]      fwd_pending;
    logic                 mc_issue;
    logic [AW-1:0]        mc_issue_dst;
    logic                 mc_done;
    logic [AW-1:0]        mc_done_dst;
    logic                 redirect;
    logic                 cnt_clr;
    logic                 stall_if;
    logic                 stall_id;
    logic                 flush_id;
    logic                 flush_ex;
    logic                 srca_mux;
    logic [XLEN-1:0]      srca_fwd;
    logic                 srcb_mux;
    logic [XLEN-1:0]      srcb_fwd;
    logic [NREG-1:0]      sb_busy;
    logic [OW-1:0]        mc_outstanding;
    logic [CNTW-1:0]      stall_cnt;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_we, id_is_mc,
               fwd_valid, fwd_dst, fwd_data, fwd_pending,
               mc_issue, mc_issue_dst, mc_done, mc_done_dst, redirect, cnt_clr,
        input  stall_if, stall_id, flush_id, flush_ex, srca_mux, srca_fwd,
               srcb_mux, srcb_fwd, sb_busy, mc_outstanding, stall_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_we, id_is_mc,
               fwd_valid, fwd_dst, fwd_data, fwd_pending,
               mc_issue, mc_issue_dst, mc_done, mc_done_dst, redirect, cnt_clr,
        output stall_if, stall_id, flush_id, flush_ex, srca_mux, srca_fwd,
               srcb_mux, srcb_fwd, sb_busy, mc_outstanding, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard unit: priority operand forwarding, load-use and
// multi-cycle scoreboard hazards, redirect arbitration and stall counting.
module hazard_scoreboard #(
    parameter int XLEN   = 64,
    parameter int NREG   = 32,
    parameter int NFWD   = 3,
    parameter int MC_MAX = 2,
    parameter int CNTW   = 32
) (
    input logic               clk,
    input logic               reset,
    hazard_scoreboard_if.slave bus
);
    localparam int AW = $clog2(NREG);
    localparam int OW = $clog2(MC_MAX + 1);

    typedef struct packed {
        logic            hit;
        logic            pend;
        logic [XLEN-1:0] data;
    } fwd_t;

    function automatic fwd_t lookup(
        input logic [AW-1:0]        rs,
        input logic                 used,
        input logic [NFWD-1:0]      valid,
        input logic [NFWD*AW-1:0]   dst,
        input logic [NFWD*XLEN-1:0] data,
        input logic [NFWD-1:0]      pend
    );
        fwd_t r;
        r = '0;
        // Oldest first so a younger match overwrites; index 0 ends up winning.
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (used && rs != '0 && valid[i] && dst[i*AW +: AW] == rs) begin
                r.hit  = 1'b1;
                r.pend = pend[i];
                r.data = data[i*XLEN +: XLEN];
            end
        end
        return r;
    endfunction

    logic [NREG-1:0] sb_busy_q, sb_busy_d;
    logic [OW-1:0]   mc_out_q, mc_out_d;
    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

    fwd_t fa, fb;
    logic haz_a, haz_b, haz_struct, hz, stall;

    always_comb begin
        fa = lookup(bus.id_rs1, bus.id_rs1_used, bus.fwd_valid, bus.fwd_dst,
                    bus.fwd_data, bus.fwd_pending);
        fb = lookup(bus.id_rs2, bus.id_rs2_used, bus.fwd_valid, bus.fwd_dst,
                    bus.fwd_data, bus.fwd_pending);
        haz_a = fa.pend || (bus.id_rs1_used && bus.id_rs1 != '0 && sb_busy_q[bus.id_rs1]);
        haz_b = fb.pend || (bus.id_rs2_used && bus.id_rs2 != '0 && sb_busy_q[bus.id_rs2]);
        haz_struct = (bus.id_is_mc && mc_out_q == OW'(MC_MAX)) ||
                     (bus.id_rd_we && bus.id_rd != '0 && sb_busy_q[bus.id_rd]);
        hz    = haz_a || haz_b || haz_struct;
        stall = hz && !bus.redirect;
    end

    assign bus.stall_if       = stall;
    assign bus.stall_id       = stall;
    assign bus.flush_id       = bus.redirect;
    assign bus.flush_ex       = hz || bus.redirect;
    assign bus.srca_mux       = fa.hit;
    assign bus.srca_fwd       = fa.data;
    assign bus.srcb_mux       = fb.hit;
    assign bus.srcb_fwd       = fb.data;
    assign bus.sb_busy        = sb_busy_q;
    assign bus.mc_outstanding = mc_out_q;
    assign bus.stall_cnt      = stall_cnt_q;

    always_comb begin
        sb_busy_d = sb_busy_q;
        if (bus.mc_done)  sb_busy_d[bus.mc_done_dst]  = 1'b0;
        // Set is applied after clear so a same-cycle issue keeps the bit.
        if (bus.mc_issue) sb_busy_d[bus.mc_issue_dst] = 1'b1;
        sb_busy_d[0] = 1'b0;

        mc_out_d = mc_out_q;
        if (bus.mc_issue && !bus.mc_done) begin
            if (mc_out_q < OW'(MC_MAX)) mc_out_d = mc_out_q + 1'b1;
        end else if (bus.mc_done && !bus.mc_issue) begin
            if (mc_out_q != '0) mc_out_d = mc_out_q - 1'b1;
        end

        stall_cnt_d = stall_cnt_q;
        if (bus.cnt_clr)                      stall_cnt_d = '0;
        else if (stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb_busy_q   <= '0;
            mc_out_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            sb_busy_q   <= sb_busy_d;
            mc_out_q    <= mc_out_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    mc_done_underflow: assert property (@(posedge clk) disable iff (!reset)
        !(bus.mc_done && mc_out_q == '0));
endmodule
